param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
Parametrised up/down counter replacing the fixed 4-bit enable counter. It adds configurable width and terminal value, a built-in enable prescaler, synchronous parallel load, direction control, and a registered terminal-count pulse. It is used as a general timer/event counter in small designs and feeds downstream control logic as a counted value plus a wrap strobe.

Parameters:
WIDTH, 8, counter bit width (>=2)
MAX_VAL, 2**WIDTH-1, terminal value for up-counting and reload value for down-count wrap (1..2**WIDTH-1)
PRESCALE, 1, number of enabled cycles per count step (>=1; 1 = step every enabled cycle)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
enable  input  1  count enable; qualified by prescaler
up_dn  input  1  1 = count up, 0 = count down; sampled each step
load  input  1  synchronous parallel load request
load_val  input  WIDTH  value loaded when load=1
count  output  WIDTH  registered counter value
tc  output  1  registered one-cycle terminal-count/wrap pulse
busy_step  output  1  combinational; high when the current cycle is a count step (enable && prescaler at terminal)

Behaviour:
- Reset (async, rst=1): count=0, tc=0, prescaler=0; all outputs are held until rst deasserts; the first step can occur at the first clk edge after deassertion.
- Prescaler: internal counter presc in 0..PRESCALE-1, increments on each enable=1 cycle. step = enable && (presc==PRESCALE-1). presc wraps to 0 on step. presc holds when enable=0. For PRESCALE=1 no presc register exists and step = enable.
- Priority per edge: rst > load > step > hold.
- Load: count <= min(load_val, MAX_VAL) (values above MAX_VAL clamp); presc <= 0; tc <= 0. A load in the same cycle as a step suppresses the step.
- Step, up_dn=1: count==MAX_VAL -> count<=0 and tc<=1; otherwise count<=count+1.
- Step, up_dn=0: count==0 -> count<=MAX_VAL and tc<=1; otherwise count<=count-1.
- tc: high for exactly one cycle, in the cycle after the wrapping edge; 0 on every other edge.
- Latency: count reflects a step/load one clk edge after the qualifying cycle.
- Direction change between steps takes effect at the next step, with no extra latency.
- Out-of-range state (count>MAX_VAL) is unreachable; no recovery logic is required.

Optional Feature:
PARAM_COUNTER_SAT_EN
- Defined: adds input port sat (1 bit). When sat=1, stepping up at MAX_VAL or down at 0 holds count and still pulses tc on every such step (saturation indication). When sat=0, behaviour is wrap as above.
- Undefined: no sat port; wrap-only behaviour.

Decomposition:
- Package param_counter_pkg: direction constants (DIR_DOWN=1'b0, DIR_UP=1'b1) and a function clamp_load(val, max).
- One sub-module: counter_prescaler (PRESCALE parameter; ports clk, rst, enable, clr, step). The top instantiates it only when PRESCALE>1.

Test Plan:
- WIDTH=4, MAX_VAL=15, PRESCALE=1; reset, then up, enable=1 for 17 cycles -> count 1..15,0,1; tc=1 only in the cycle after count goes 15->0.
- MAX_VAL=9, down from load_val=2, enable=1 -> count 1,0,9,8; tc pulses once after 0->9.
- PRESCALE=3, up, enable toggled 1,1,0,1 -> count increments only on the 3rd enabled cycle; busy_step high in that cycle only.
- load=1 with load_val=12, MAX_VAL=9, concurrent with a step -> count=9 next cycle, no step applied, presc=0, tc=0.
- rst asserted mid-count (count=7, presc=2) between edges -> count=0 and tc=0 immediately, without waiting for clk; normal counting resumes after deassertion.
- With PARAM_COUNTER_SAT_EN and sat=1, up at MAX_VAL=15 for 3 steps -> count stays 15; tc pulses after each step.

Source files
------------

// File: rtl/param_counter_pkg.sv
// ----------------------------------------------------------------------------
// param_counter_pkg
// This package holds the constants and helpers shared by param_updown_counter
// and its prescaler.
//   DIR_DOWN / DIR_UP : encodings of the up_dn input
//   clamp_load()      : limits a parallel-load value to the terminal value
// ----------------------------------------------------------------------------
package param_counter_pkg;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   // Returns val limited to max, so a load can never leave the counter
   // above its terminal value.
   function automatic int unsigned clamp_load(input int unsigned val,
                                              input int unsigned max);
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// ----------------------------------------------------------------------------
// counter_prescaler
// This module divides the count enable. It produces one step every PRESCALE
// enabled cycles. The top instantiates it only when PRESCALE > 1.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset (presc -> 0)
//   enable : count enable; presc advances on every enabled cycle
//   clr    : synchronous clear of presc (used by a parallel load)
//   step   : combinational, enable && presc at PRESCALE-1
// ----------------------------------------------------------------------------
module counter_prescaler #(
   parameter int unsigned PRESCALE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clr,
   output logic step
);

   localparam int unsigned    PW         = $clog2(PRESCALE);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);

   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;

   assign step = enable && (presc_q == PRESC_LAST);

   // NOTE: every variable assigned in always_comb gets a default value first.
   // Without it, any path that skips the assignment infers a latch.
   always_comb begin
      presc_d = presc_q;
      if (clr) begin
         presc_d = '0;
      end else if (step) begin
         presc_d = '0;
      end else if (enable) begin
         presc_d = presc_q + PRESC_ONE;
      end
   end

   // NOTE: sequential state is updated only with non-blocking (<=)
   // assignments. This lets every flop sample the values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

endmodule

// File: rtl/param_updown_counter.sv
// ----------------------------------------------------------------------------
// param_updown_counter
// This is a parametrised up/down counter with an enable prescaler,
// a synchronous parallel load (clamped to MAX_VAL) and a registered
// one-cycle terminal-count pulse.
// Priority per edge: rst > load > step > hold.
// Optional feature macro: PARAM_COUNTER_SAT_EN adds input 'sat'. When it is
// high, a step past a terminal value holds count and still pulses tc.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   enable    : count enable, qualified by the prescaler
//   up_dn     : 1 = up, 0 = down, sampled on each step
//   load      : synchronous parallel load request
//   load_val  : value loaded (clamped to MAX_VAL)
//   sat       : (PARAM_COUNTER_SAT_EN only) saturate instead of wrap
//   count     : registered counter value
//   tc        : registered one-cycle wrap/terminal pulse
//   busy_step : combinational, high in a cycle that is a count step
// ----------------------------------------------------------------------------
module param_updown_counter
   import param_counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef PARAM_COUNTER_SAT_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy_step
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

   logic             step;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             at_end;
   logic [WIDTH-1:0] wrap_val;

   generate
      if (PRESCALE > 1) begin : g_presc
         counter_prescaler #(
            .PRESCALE (PRESCALE)
         ) u_presc (
            .clk    (clk),
            .rst    (rst),
            .enable (enable),
            .clr    (load),
            .step   (step)
         );
      end else begin : g_no_presc
         assign step = enable;
      end
   endgenerate

   // at_end is high when the next step in the current direction crosses a terminal value.
   assign at_end   = (up_dn == DIR_UP) ? (count_q == MAX_C) : (count_q == '0);
   assign wrap_val = (up_dn == DIR_UP) ? '0 : MAX_C;

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (load) begin
         // A load wins over a coincident step; the step is dropped.
         count_d = WIDTH'(clamp_load(32'(load_val), MAX_VAL));
      end else if (step) begin
         if (at_end) begin
            tc_d = 1'b1;
`ifdef PARAM_COUNTER_SAT_EN
            count_d = sat ? count_q : wrap_val;
`else
            count_d = wrap_val;
`endif
         end else if (up_dn == DIR_UP) begin
            count_d = count_q + ONE_C;
         end else begin
            count_d = count_q - ONE_C;
         end
      end
   end

   // NOTE: only the architectural state is reset. Reset forces the outputs
   // to their idle values immediately, before any clock edge arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign count     = count_q;
   assign tc        = tc_q;
   assign busy_step = step;

endmodule

// File: tb/tb_param_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_param_updown_counter
// This bench drives two counter instances:
//   A : WIDTH=4, MAX_VAL=15, PRESCALE=1
//   B : WIDTH=4, MAX_VAL=9,  PRESCALE=3
// It runs directed sequences, a table of vectors on B, an asynchronous reset
// in the middle of a count, an optional saturation sequence and a random
// phase. The random phase is checked against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_param_updown_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       en_a = 1'b0, up_a = 1'b0, ld_a = 1'b0;
   logic [3:0] lv_a = '0;
   logic [3:0] cnt_a;
   logic       tc_a, bs_a;

   logic       en_b = 1'b0, up_b = 1'b0, ld_b = 1'b0;
   logic [3:0] lv_b = '0;
   logic [3:0] cnt_b;
   logic       tc_b, bs_b;

   logic       sat_a = 1'b0, sat_b = 1'b0;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .enable    (en_a),
      .up_dn     (up_a),
      .load      (ld_a),
      .load_val  (lv_a),
`ifdef PARAM_COUNTER_SAT_EN
      .sat       (sat_a),
`endif
      .count     (cnt_a),
      .tc        (tc_a),
      .busy_step (bs_a)
   );

   param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .enable    (en_b),
      .up_dn     (up_b),
      .load      (ld_b),
      .load_val  (lv_b),
`ifdef PARAM_COUNTER_SAT_EN
      .sat       (sat_b),
`endif
      .count     (cnt_b),
      .tc        (tc_b),
      .busy_step (bs_b)
   );

   // Reference model. The count lives in the ring 0..MAX, and a step moves
   // it by +1 or -1 modulo MAX+1.
   // The prescaler counts enabled cycles modulo PRESCALE.
   int unsigned maxv[2] = '{15, 9};
   int unsigned ps[2]   = '{1, 3};
   int unsigned m_cnt[2];
   int unsigned m_presc[2];
   bit          m_tc[2];

   function automatic bit model_busy(input int k, input bit en);
      return en && (m_presc[k] == ps[k] - 1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k]   = 0;
         m_presc[k] = 0;
         m_tc[k]    = 0;
      end
   endtask

   task automatic model_edge(input int k, input bit en, input bit up, input bit ld,
                             input int unsigned lv, input bit sat);
      bit          stp;
      bit          crosses;
      int unsigned nxt;
      stp = model_busy(k, en);
      if (ld) begin
         m_cnt[k]   = (lv > maxv[k]) ? maxv[k] : lv;
         m_presc[k] = 0;
         m_tc[k]    = 0;
      end else begin
         if (en) m_presc[k] = (m_presc[k] + 1) % ps[k];
         m_tc[k] = 0;
         if (stp) begin
            nxt     = up ? (m_cnt[k] + 1) % (maxv[k] + 1)
                         : (m_cnt[k] + maxv[k]) % (maxv[k] + 1);
            crosses = up ? (nxt < m_cnt[k]) : (nxt > m_cnt[k]);
            m_tc[k] = crosses;
            if (!(crosses && sat)) m_cnt[k] = nxt;
         end
      end
   endtask

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Applies one rising edge to both instances and to the model.
   // The caller must have set all inputs beforehand.
   task automatic clock_edge();
      @(posedge clk);
      model_edge(0, en_a, up_a, ld_a, lv_a, sat_a);
      model_edge(1, en_b, up_b, ld_b, lv_b, sat_b);
      #1;
   endtask

   typedef struct {
      bit          en;
      bit          up;
      bit          ld;
      int unsigned lv;
      bit          busy;
      int unsigned cnt;
      bit          tc;
   } vec_t;

   vec_t tbl[18];

   initial begin
      tbl = '{
         '{0, 0, 1,  2, 0, 2, 0},   // load 2
         '{1, 0, 0,  0, 0, 2, 0},   // enabled 1
         '{1, 0, 0,  0, 0, 2, 0},   // enabled 2
         '{0, 0, 0,  0, 0, 2, 0},   // enable low: prescaler holds
         '{1, 0, 0,  0, 1, 1, 0},   // enabled 3: step down
         '{1, 0, 0,  0, 0, 1, 0},
         '{1, 0, 0,  0, 0, 1, 0},
         '{1, 0, 0,  0, 1, 0, 0},   // step to 0
         '{1, 0, 0,  0, 0, 0, 0},
         '{1, 0, 0,  0, 0, 0, 0},
         '{1, 0, 0,  0, 1, 9, 1},   // wrap 0 -> 9, tc
         '{1, 0, 0,  0, 0, 9, 0},   // tc lasts one cycle
         '{1, 0, 0,  0, 0, 9, 0},
         '{1, 0, 1, 12, 1, 9, 0},   // load 12 clamps to 9, step dropped
         '{1, 1, 0,  0, 0, 9, 0},   // prescaler restarted by load
         '{1, 1, 0,  0, 0, 9, 0},
         '{1, 1, 0,  0, 1, 0, 1},   // wrap 9 -> 0 upward
         '{0, 1, 0,  0, 0, 0, 0}
      };

      model_reset();

      // Reset state.
      #12;
      check("reset count_a", cnt_a, 0);
      check("reset tc_a", tc_a, 0);
      check("reset count_b", cnt_b, 0);
      check("reset tc_b", tc_b, 0);
      rst = 1'b0;

      // A: up for 17 steps, wrapping once.
      en_a = 1'b1;
      up_a = 1'b1;
      #1;
      check("a busy_step with enable", bs_a, 1);
      for (int i = 1; i <= 17; i++) begin
         clock_edge();
         check($sformatf("a up step %0d count", i), cnt_a, i % 16);
         check($sformatf("a up step %0d tc", i), tc_a, (i == 16) ? 1 : 0);
      end
      en_a = 1'b0;

      // B: table of vectors.
      for (int i = 0; i < 18; i++) begin
         en_b = tbl[i].en;
         up_b = tbl[i].up;
         ld_b = tbl[i].ld;
         lv_b = 4'(tbl[i].lv);
         #1;
         check($sformatf("tbl[%0d] busy_step", i), bs_b, tbl[i].busy);
         clock_edge();
         check($sformatf("tbl[%0d] count", i), cnt_b, tbl[i].cnt);
         check($sformatf("tbl[%0d] tc", i), tc_b, tbl[i].tc);
      end

      // B: reach count=7 with presc=2, then reset asynchronously between edges.
      en_b = 1'b0; ld_b = 1'b1; lv_b = 4'd7;
      clock_edge();
      ld_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
      clock_edge();
      clock_edge();
      check("pre-reset count_b", cnt_b, 7);
      check("pre-reset busy_b", bs_b, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async reset count_b", cnt_b, 0);
      check("async reset tc_b", tc_b, 0);
      check("async reset busy_b (presc cleared)", bs_b, 0);
      check("async reset count_a", cnt_a, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) clock_edge();
      check("resume after reset count_b", cnt_b, 1);

`ifdef PARAM_COUNTER_SAT_EN
      // A: saturate at MAX_VAL for three steps.
      en_b = 1'b0;
      en_a = 1'b0; ld_a = 1'b1; lv_a = 4'd15;
      clock_edge();
      ld_a = 1'b0; en_a = 1'b1; up_a = 1'b1; sat_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clock_edge();
         check($sformatf("sat step %0d count", i), cnt_a, 15);
         check($sformatf("sat step %0d tc", i), tc_a, 1);
      end
      sat_a = 1'b0;
      en_a = 1'b0;
`endif

      // Random phase against the reference model.
      for (int i = 0; i < 400; i++) begin
         en_a = ($urandom_range(3) != 0);
         up_a = 1'($urandom_range(1));
         ld_a = ($urandom_range(15) == 0);
         lv_a = 4'($urandom_range(15));
         en_b = ($urandom_range(3) != 0);
         up_b = 1'($urandom_range(1));
         ld_b = ($urandom_range(15) == 0);
         lv_b = 4'($urandom_range(15));
`ifdef PARAM_COUNTER_SAT_EN
         sat_a = 1'($urandom_range(1));
         sat_b = 1'($urandom_range(1));
`endif
         #1;
         check($sformatf("rand %0d busy_a", i), bs_a, model_busy(0, en_a));
         check($sformatf("rand %0d busy_b", i), bs_b, model_busy(1, en_b));
         clock_edge();
         check($sformatf("rand %0d count_a", i), cnt_a, m_cnt[0]);
         check($sformatf("rand %0d tc_a", i), tc_a, m_tc[0]);
         check($sformatf("rand %0d count_b", i), cnt_b, m_cnt[1]);
         check($sformatf("rand %0d tc_b", i), tc_b, m_tc[1]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
